rr_arbiter4: RTL and testbench
==============================

Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one datapath slot (e.g. an encoder/estimator lane) among four clients.
- Issues a registered one-hot grant, plus a 2-bit encoded grant index and a valid flag.
- Bounds the time any one owner can hold the slot.
- Counts grant hand-overs as a switching-activity figure for the power-estimation flow.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one owner holds the grant while others are waiting. Legal range 2..255.
- CNT_W, 16: width of the grant-switch activity counter.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- arb_en  input  1  enables issuing of new grants
- req  input  4  request vector; bit i is requester i, level-sensitive
- gnt  output  4  one-hot grant, registered
- gnt_idx  output  2  binary index of the asserted gnt bit; 0 when none
- gnt_valid  output  1  high when any gnt bit is high
- sw_clr  input  1  synchronous clear of sw_cnt
- sw_cnt  output  CNT_W  saturating count of new grants issued

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - gnt=0, gnt_idx=0, gnt_valid=0, sw_cnt=0.
  - Rotation pointer ptr=0, hold counter hold_cnt=0, state=IDLE.
- States:
  - IDLE: no owner.
  - BUSY: owner holds gnt.
- Pick function:
  - Scan req starting at index ptr, then ptr+1, ptr+2, ptr+3 (mod 4).
  - The first set bit wins.
  - Used whenever a new grant is issued.
- IDLE:
  - If arb_en=1 and req≠0, the winner's gnt bit goes high on the next edge (latency 1 cycle from sampled req). State becomes BUSY.
  - Otherwise stay in IDLE with gnt=0.
- BUSY, with owner o:
  - Release: req[o]=0 sampled.
    - If arb_en=1 and another req is set, the next edge hands over directly to the pick winner, with no idle cycle.
    - Otherwise gnt=0 and state goes to IDLE.
  - Forced rotation: req[o]=1, hold_cnt=MAX_HOLD-1, and at least one other req is set.
    - If arb_en=1, the next edge grants the pick winner, which is never o because ptr=o+1.
    - If arb_en=0, o keeps the grant and hold_cnt stays at MAX_HOLD-1.
  - req[o]=1 with no other request: o keeps the grant. hold_cnt saturates at MAX_HOLD-1. No forced release.
  - Otherwise o keeps the grant and hold_cnt increments.
- On every new grant:
  - ptr ← (winner+1) mod 4.
  - hold_cnt ← 0.
  - sw_cnt increments, saturating at 2^CNT_W-1.
- Grant-switch counting:
  - Re-granting the same requester after an IDLE gap counts as a new grant.
  - A continuing hold never counts.
- arb_en=0 blocks new grants only. An existing grant continues until released by its owner.
- sw_clr=1 clears sw_cnt on the next edge. If sw_clr and a new grant occur in the same cycle, sw_cnt ← 0 (clear wins).
- gnt_idx and gnt_valid are derived combinationally from registered gnt:
  - gnt_idx is the 4→2 encoding of gnt.
  - gnt is always one-hot or zero. No illegal multi-hot state is reachable.
- Simultaneous requests are resolved by ptr order only. After reset the priority is 0>1>2>3.
- A request that drops before it is granted is simply not granted. No memory is kept of transient requests.

Decomposition:
- Shared package rr_arb_pkg holds:
  - state encoding (IDLE=1'b0, BUSY=1'b1);
  - constant N_REQ=4;
  - constant IDX_W=2.
- One sub-module, rr_pick4 (combinational). Inputs req[3:0], ptr[1:0]. Outputs win_idx[1:0] and any. It performs rotate, priority-encode, and un-rotate.
- All state, pointer, hold counter and activity counter live in rr_arbiter4.

Test Plan:
- Reset then req=4'b0101, arb_en=1 → one cycle later gnt=0001, gnt_idx=0, gnt_valid=1, sw_cnt=1. After req[0] drops → next cycle gnt=0100, gnt_idx=2, sw_cnt=2.
- req=4'b1111 held constant, MAX_HOLD=8 → grant order 0,1,2,3,0, each owner for exactly 8 cycles. sw_cnt increases by 1 per hand-over.
- Only req[3]=1 for 20 cycles → gnt=1000 throughout, sw_cnt=1, no forced release.
- Owner 1 granted, arb_en←0, req[1] drops while req[2]=1 → gnt=0 and state IDLE. arb_en←1 → next cycle gnt=0100.
- rst_n asserted low mid-grant, between clock edges → gnt, gnt_idx, gnt_valid and sw_cnt go to 0 immediately. After release, req=4'b1010 → gnt=0010 (ptr back to 0).
- CNT_W=2, six alternating grants → sw_cnt saturates at 3. sw_cnt=3 with sw_clr=1 and a new grant in the same cycle → sw_cnt=0.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package rr_arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Encode a one-hot (or all-zero) grant vector to its binary index; zero maps to 0.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    onehot_to_idx = {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the clients (master side) and the arbiter (slave side).
// Handshake: req[i] is a level held by client i for as long as it wants the slot;
// the slot belongs to client i in every cycle where gnt[i] is high, and the client
// gives it back simply by dropping req[i]. There is no separate ready/accept signal.
interface rr_arbiter4_if #(
  parameter int CNT_W = 16
);
  import rr_arb_pkg::*;

  logic                arb_en;
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_valid;
  logic                sw_clr;
  logic [CNT_W-1:0]    sw_cnt;
  arb_state_e          state_dbg;

  modport master (
    output arb_en, req, sw_clr,
    input  gnt, gnt_idx, gnt_valid, sw_cnt, state_dbg
  );

  modport slave (
    input  arb_en, req, sw_clr,
    output gnt, gnt_idx, gnt_valid, sw_cnt, state_dbg
  );

endinterface

// File: rtl/rr_pick4.sv
// Round-robin pick: rotate req so ptr sits at bit 0, take the lowest set bit,
// then rotate the index back into requester numbering.
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  // Rotate, priority-encode from the pointer upward, un-rotate.
  always_comb begin
    dbl = {req, req};
    rot = dbl[ptr +: N_REQ];
    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = IDX_W'(k);
    end
    win_idx = off + ptr;
    any     = |req;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a bounded hold time and a saturating
// grant-switch counter used as an activity figure for power estimation.
module rr_arbiter4
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_arbiter4_if.slave     bus
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_e        state_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [7:0]        hold_q;
  logic [CNT_W-1:0]  sw_q;

  logic [IDX_W-1:0]  win_idx;
  logic              any_req;
  logic [IDX_W-1:0]  own_idx;
  logic              own_req;
  logic              others;
  logic              grant_new;
  logic              go_idle;
  logic [7:0]        hold_nxt;

  rr_pick4 u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .win_idx (win_idx),
    .any     (any_req)
  );

  assign own_idx = onehot_to_idx(gnt_q);
  assign own_req = bus.req[own_idx];
  // Requests from anyone other than the current owner (gnt_q is zero when idle).
  assign others  = |(bus.req & ~gnt_q);

  // Decide whether this edge issues a new grant, drops to idle, or continues the hold.
  always_comb begin
    grant_new = 1'b0;
    go_idle   = 1'b0;
    hold_nxt  = hold_q;
    case (state_q)
      IDLE: begin
        grant_new = bus.arb_en & any_req;
      end
      BUSY: begin
        if (!own_req) begin
          if (bus.arb_en && others) grant_new = 1'b1;
          else                      go_idle   = 1'b1;
        end else if (others) begin
          // Owner has used its full slice: rotate away if new grants are allowed,
          // otherwise keep holding at the limit.
          if (hold_q == HOLD_LAST) grant_new = bus.arb_en;
          else                     hold_nxt  = hold_q + 8'd1;
        end else if (hold_q != HOLD_LAST) begin
          hold_nxt = hold_q + 8'd1;
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  // Arbitration FSM: state, registered one-hot grant, rotation pointer, hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else if (grant_new) begin
      state_q <= BUSY;
      gnt_q   <= N_REQ'(1) << win_idx;
      ptr_q   <= win_idx + IDX_W'(1);
      hold_q  <= '0;
    end else if (go_idle) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      hold_q  <= hold_nxt;
    end
  end

  // Saturating count of new grants; a clear in the same cycle takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_q <= '0;
    end else if (bus.sw_clr) begin
      sw_q <= '0;
    end else if (grant_new && (sw_q != {CNT_W{1'b1}})) begin
      sw_q <= sw_q + CNT_W'(1);
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = own_idx;
  assign bus.gnt_valid = |gnt_q;
  assign bus.sw_cnt    = sw_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: two instances (16-bit and 2-bit activity counter) driven
// with identical stimulus and compared every cycle against a behavioural model.
module tb_rr_arbiter4;
  import rr_arb_pkg::*;

  localparam int MH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fails = 0;

  rr_arbiter4_if #(.CNT_W(16)) if0 ();
  rr_arbiter4_if #(.CNT_W(2))  if1 ();

  rr_arbiter4 #(.MAX_HOLD(MH), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  rr_arbiter4 #(.MAX_HOLD(MH), .CNT_W(2))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // clock and reset
  always #5 clk = ~clk;

  // behavioural model: owner (-1 = none), rotation start, cycles held, grant counts
  int m_owner, m_ptr, m_hold, m_sw0, m_sw1;

  logic [33:0] obs;
  assign obs = {if0.gnt, if0.gnt_idx, if0.gnt_valid, if0.sw_cnt,
                if1.gnt, if1.gnt_idx, if1.gnt_valid, if1.sw_cnt,
                logic'(if0.state_dbg), logic'(if1.state_dbg)};

  function automatic logic [33:0] exp_vec();
    logic [3:0] g;
    logic [1:0] ix;
    logic       v;
    g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    ix = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    v  = (m_owner >= 0);
    return {g, ix, v, 16'(m_sw0), g, ix, v, 2'(m_sw1), v, v};
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_hold = 0; m_sw0 = 0; m_sw1 = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input bit en, input bit clr);
    int  win;
    bit  others, grant;
    win = -1;
    for (int k = 0; k < 4; k++)
      if (win < 0 && r[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
    others = 0;
    for (int i = 0; i < 4; i++) if (r[i] && i != m_owner) others = 1;
    grant = 0;
    if (m_owner < 0) begin
      grant = en && (r != 0);
    end else if (!r[m_owner]) begin
      if (en && others) grant = 1;
      else m_owner = -1;
    end else if (others) begin
      if (m_hold == MH - 1) grant = en;
      else m_hold++;
    end else if (m_hold < MH - 1) begin
      m_hold++;
    end
    if (grant) begin
      m_owner = win;
      m_ptr   = (win + 1) % 4;
      m_hold  = 0;
    end
    if (clr) begin
      m_sw0 = 0; m_sw1 = 0;
    end else if (grant) begin
      if (m_sw0 < 65535) m_sw0++;
      if (m_sw1 < 3) m_sw1++;
    end
  endtask

  // driver: apply inputs, let one edge happen, advance the model, settle
  task automatic tick(input logic [3:0] r, input bit en, input bit clr);
    if0.req = r; if0.arb_en = en; if0.sw_clr = clr;
    if1.req = r; if1.arb_en = en; if1.sw_clr = clr;
    @(posedge clk);
    model_step(r, en, clr);
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (obs !== 34'd0) begin
      n_fails++;
      $display("FAIL reset_outputs got=%h want=%h", obs, 34'd0);
    end
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fails++;
      $display("FAIL reset_model got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_basic();
    tick(4'b0101, 1'b1, 1'b0);
    n_checks++;
    if ({if0.gnt, if0.gnt_idx, if0.gnt_valid, if0.sw_cnt} !== {4'b0001, 2'd0, 1'b1, 16'd1}) begin
      n_fails++;
      $display("FAIL basic_first got=%b/%0d/%b/%0d want=0001/0/1/1",
               if0.gnt, if0.gnt_idx, if0.gnt_valid, if0.sw_cnt);
    end
    tick(4'b0100, 1'b1, 1'b0);
    n_checks++;
    if ({if0.gnt, if0.gnt_idx, if0.sw_cnt} !== {4'b0100, 2'd2, 16'd2}) begin
      n_fails++;
      $display("FAIL basic_handover got=%b/%0d/%0d want=0100/2/2",
               if0.gnt, if0.gnt_idx, if0.sw_cnt);
    end
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fails++;
      $display("FAIL basic_model got=%h want=%h", obs, exp_vec());
    end
    tick(4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_rotation();
    int runs_bad;
    int run_len;
    logic [3:0] last;
    runs_bad = 0; run_len = 0; last = 4'd0;
    for (int c = 0; c < 5 * MH + 1; c++) begin
      tick(4'b1111, 1'b1, 1'b0);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fails++;
        $display("FAIL rotation_cycle%0d got=%h want=%h", c, obs, exp_vec());
      end
      if (if0.gnt != last) begin
        if (last != 4'd0 && run_len != MH) runs_bad++;
        run_len = 1; last = if0.gnt;
      end else begin
        run_len++;
      end
    end
    n_checks++;
    if (runs_bad != 0) begin
      n_fails++;
      $display("FAIL rotation_slice_len bad_runs=%0d want=0", runs_bad);
    end
    tick(4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_single_holder();
    int bad;
    bad = 0;
    tick(4'b0000, 1'b1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      tick(4'b1000, 1'b1, 1'b0);
      if (if0.gnt !== 4'b1000 || obs !== exp_vec()) bad++;
    end
    n_checks++;
    if (bad != 0 || if0.sw_cnt !== 16'd1) begin
      n_fails++;
      $display("FAIL single_holder bad_cycles=%0d sw_cnt=%0d want=0/1", bad, if0.sw_cnt);
    end
    tick(4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_arb_en();
    tick(4'b0010, 1'b1, 1'b0);
    n_checks++;
    if (if0.gnt !== 4'b0010) begin
      n_fails++;
      $display("FAIL arb_en_own1 got=%b want=0010", if0.gnt);
    end
    tick(4'b0010, 1'b0, 1'b0);
    tick(4'b0100, 1'b0, 1'b0);
    n_checks++;
    if (if0.gnt !== 4'b0000 || if0.state_dbg !== IDLE) begin
      n_fails++;
      $display("FAIL arb_en_blocked got=%b/%0d want=0000/0", if0.gnt, if0.state_dbg);
    end
    tick(4'b0100, 1'b1, 1'b0);
    n_checks++;
    if (if0.gnt !== 4'b0100 || obs !== exp_vec()) begin
      n_fails++;
      $display("FAIL arb_en_resume got=%b want=0100", if0.gnt);
    end
  endtask

  task automatic test_async_reset();
    tick(4'b0100, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (obs !== 34'd0) begin
      n_fails++;
      $display("FAIL async_reset got=%h want=%h", obs, 34'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(4'b1010, 1'b1, 1'b0);
    n_checks++;
    if (if0.gnt !== 4'b0010 || obs !== exp_vec()) begin
      n_fails++;
      $display("FAIL async_reset_ptr got=%b want=0010", if0.gnt);
    end
    tick(4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_saturation();
    tick(4'b0000, 1'b1, 1'b1);
    for (int c = 0; c < 6; c++) tick((c % 2 == 0) ? 4'b0001 : 4'b0010, 1'b1, 1'b0);
    n_checks++;
    if (if1.sw_cnt !== 2'd3 || if0.sw_cnt !== 16'd6) begin
      n_fails++;
      $display("FAIL sat_count got=%0d/%0d want=3/6", if1.sw_cnt, if0.sw_cnt);
    end
    tick(4'b0001, 1'b1, 1'b1);
    n_checks++;
    if (if1.sw_cnt !== 2'd0 || if0.sw_cnt !== 16'd0 || if0.gnt !== 4'b0001) begin
      n_fails++;
      $display("FAIL clr_wins got=%0d/%0d/%b want=0/0/0001", if1.sw_cnt, if0.sw_cnt, if0.gnt);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    bit en, clr;
    int hold_for;
    int bad;
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold_for == 0) begin
        r = 4'($urandom_range(0, 15));
        en = ($urandom_range(0, 7) != 0);
        hold_for = $urandom_range(1, 14);
      end
      hold_for--;
      clr = ($urandom_range(0, 40) == 0);
      tick(r, en, clr);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fails++;
        bad++;
        if (bad < 10) $display("FAIL random_cycle%0d got=%h want=%h", c, obs, exp_vec());
      end
    end
  endtask

  initial begin
    if0.req = '0; if0.arb_en = 1'b0; if0.sw_clr = 1'b0;
    if1.req = '0; if1.arb_en = 1'b0; if1.sw_clr = 1'b0;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_rotation();
    test_single_holder();
    test_arb_en();
    test_async_reset();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
